// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: a TX FIFO that the bus pops and an RX FIFO that the bus pushes into.
// The RX side filters packets by destination ID and keeps sticky overflow and misroute status.
module bus_dev_endpoint #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic               rx_overflow,
  output logic [7:0]         misroute_cnt
);

  localparam int unsigned AW       = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

  // ---------------- TX FIFO ----------------
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [AW-1:0]      tx_wptr_q, tx_wptr_d;
  logic [AW-1:0]      tx_rptr_q, tx_rptr_d;
  logic [AW:0]        tx_cnt_q, tx_cnt_d;
  logic               tx_empty, tx_wr_ok, tx_rd_ok;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign pndng    = !tx_empty;
  assign D_pop    = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign tx_rd_ok = pop && !tx_empty;
  // A write into a full FIFO still lands when the same cycle frees a slot.
  assign tx_wr_ok = tx_wr && (!tx_full || tx_rd_ok);

  always_comb begin
    tx_wptr_d = tx_wptr_q + AW'(tx_wr_ok);
    tx_rptr_d = tx_rptr_q + AW'(tx_rd_ok);
    tx_cnt_d  = tx_cnt_q + (AW+1)'(tx_wr_ok) - (AW+1)'(tx_rd_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem_q[tx_wptr_q] <= tx_data;
  end

  // ---------------- RX FIFO ----------------
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [AW-1:0]      rx_wptr_q, rx_wptr_d;
  logic [AW-1:0]      rx_rptr_q, rx_rptr_d;
  logic [AW:0]        rx_cnt_q, rx_cnt_d;
  logic               rx_full, rx_wr_ok, rx_rd_ok, rx_hit;
  logic [7:0]         rx_dest;
  logic               ovf_q, ovf_d;
  logic [7:0]         mis_q, mis_d;

  assign rx_dest  = D_push[pckg_sz-1 -: 8];
  assign rx_hit   = (rx_dest == id) || (rx_dest == broadcast);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_data  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign rx_rd_ok = rx_rd && !rx_empty;
  assign rx_wr_ok = push && rx_hit && (!rx_full || rx_rd_ok);

  assign rx_overflow  = ovf_q;
  assign misroute_cnt = mis_q;

  always_comb begin
    rx_wptr_d = rx_wptr_q + AW'(rx_wr_ok);
    rx_rptr_d = rx_rptr_q + AW'(rx_rd_ok);
    rx_cnt_d  = rx_cnt_q + (AW+1)'(rx_wr_ok) - (AW+1)'(rx_rd_ok);
    ovf_d     = ovf_q | (push && rx_hit && !rx_wr_ok);
    mis_d     = mis_q;
    if (push && !rx_hit && (mis_q != 8'hFF)) mis_d = mis_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 8'd0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_q     <= ovf_d;
      mis_q     <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr_ok) rx_mem_q[rx_wptr_q] <= D_push;
  end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Scoreboard bench for bus_dev_endpoint: stimulus queues expected packets, a monitor checks
// them as the bus pops TX or the host reads RX; status outputs are checked inline.
module tb_bus_dev_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_empty, rx_overflow;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  misroute_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];

  bus_dev_endpoint #(.pckg_sz(16), .depth(8), .id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_overflow(rx_overflow), .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [15:0] d, input bit acc);
    tx_wr = 1'b1;
    tx_data = d;
    if (acc) tx_q.push_back(d);
    cyc();
    tx_wr = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d, input bit acc);
    push = 1'b1;
    D_push = d;
    if (acc) rx_q.push_back(d);
    cyc();
    push = 1'b0;
  endtask

  // Monitor: compare whenever a transfer actually happens at the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (pop && pndng) begin
        if (tx_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_extra: D_pop=%0h with nothing expected", D_pop);
        end else chk("tx_order", 32'(D_pop), 32'(tx_q.pop_front()));
      end
      if (rx_rd && !rx_empty) begin
        if (rx_q.size() == 0) begin
          n_total++;
          $display("FAIL rx_extra: rx_data=%0h with nothing expected", rx_data);
        end else chk("rx_order", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d1, d2;
    reset = 1'b1; tx_wr = 1'b1; tx_data = 16'h1234; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_rd = 1'b0;

    // Reset with tx_wr held
    repeat (3) begin
      @(negedge clk);
      chk("rst_pndng",    32'(pndng),        32'd0);
      chk("rst_dpop",     32'(D_pop),        32'd0);
      chk("rst_rx_empty", 32'(rx_empty),     32'd1);
      chk("rst_misroute", 32'(misroute_cnt), 32'd0);
    end
    chk("rst_tx_full", 32'(tx_full),     32'd0);
    chk("rst_rx_data", 32'(rx_data),     32'd0);
    chk("rst_ovf",     32'(rx_overflow), 32'd0);
    cyc();
    reset = 1'b0;
    tx_q.push_back(16'h1234);
    #1;
    chk("release_pndng", 32'(pndng), 32'd0);
    cyc();
    tx_wr = 1'b0;
    chk("first_wr_pndng", 32'(pndng), 32'd1);
    chk("first_wr_dpop",  32'(D_pop), 32'h1234);
    pop = 1'b1; cyc(); pop = 1'b0;
    chk("first_pop_empty", 32'(pndng), 32'd0);

    // Three writes, three back-to-back pops
    tx_write(16'h0301, 1'b1);
    tx_write(16'h05AA, 1'b1);
    tx_write(16'hFF10, 1'b1);
    chk("tx3_head", 32'(D_pop), 32'h0301);
    pop = 1'b1;
    cyc(); cyc();
    chk("tx3_pndng_mid", 32'(pndng), 32'd1);
    cyc();
    pop = 1'b0;
    chk("tx3_pndng_end", 32'(pndng), 32'd0);
    chk("tx3_dpop_end",  32'(D_pop), 32'd0);

    // Fill, drop on full, write+pop while full
    for (int i = 0; i < 8; i++) begin
      chk("fill_not_full", 32'(tx_full), 32'd0);
      tx_write(16'h0A00 + 16'(i), 1'b1);
    end
    chk("fill_full", 32'(tx_full), 32'd1);
    tx_write(16'hBAD0, 1'b0);
    chk("drop_still_full", 32'(tx_full), 32'd1);
    chk("drop_head", 32'(D_pop), 32'h0A00);
    tx_wr = 1'b1; tx_data = 16'h0C0C; pop = 1'b1;
    tx_q.push_back(16'h0C0C);
    cyc();
    tx_wr = 1'b0; pop = 1'b0;
    chk("wrpop_full", 32'(tx_full), 32'd1);
    chk("wrpop_head", 32'(D_pop), 32'h0A01);
    pop = 1'b1; repeat (8) cyc(); pop = 1'b0;
    chk("drain_pndng", 32'(pndng), 32'd0);

    // RX destination filtering
    rx_push(16'h0311, 1'b1);
    rx_push(16'hFF22, 1'b1);
    rx_push(16'h0433, 1'b0);
    chk("rx_misroute_1", 32'(misroute_cnt), 32'd1);
    chk("rx_ovf_0",      32'(rx_overflow),  32'd0);
    chk("rx_head",       32'(rx_data),      32'h0311);
    rx_rd = 1'b1; cyc(); cyc(); rx_rd = 1'b0;
    chk("rx_drained",    32'(rx_empty),     32'd1);
    chk("rx_data_empty", 32'(rx_data),      32'd0);

    // RX overflow
    for (int i = 0; i < 8; i++) rx_push(16'h0340 + 16'(i), 1'b1);
    chk("ovf_before", 32'(rx_overflow), 32'd0);
    rx_push(16'h03EE, 1'b0);
    chk("ovf_set",  32'(rx_overflow), 32'd1);
    chk("ovf_head", 32'(rx_data),     32'h0340);
    rx_rd = 1'b1; repeat (8) cyc(); rx_rd = 1'b0;
    chk("ovf_sticky",   32'(rx_overflow), 32'd1);
    chk("ovf_rx_empty", 32'(rx_empty),    32'd1);

    // Streaming across pointer wrap with 4 entries in flight
    for (int i = 0; i < 4; i++) begin
      tx_write(16'h0300 | 16'($urandom_range(0, 255)), 1'b1);
      rx_push(16'h0300 | 16'($urandom_range(0, 255)), 1'b1);
    end
    tx_wr = 1'b1; pop = 1'b1; push = 1'b1; rx_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d1 = 16'h0300 | 16'($urandom_range(0, 255));
      d2 = 16'h0300 | 16'($urandom_range(0, 255));
      tx_data = d1; tx_q.push_back(d1);
      D_push  = d2; rx_q.push_back(d2);
      cyc();
    end
    tx_wr = 1'b0; push = 1'b0;
    repeat (4) cyc();
    pop = 1'b0; rx_rd = 1'b0;
    chk("stream_tx_done", 32'(pndng),    32'd0);
    chk("stream_rx_done", 32'(rx_empty), 32'd1);
    chk("tx_q_drained",   32'(tx_q.size()), 32'd0);
    chk("rx_q_drained",   32'(rx_q.size()), 32'd0);

    // Misroute saturation (count starts at 1)
    for (int i = 1; i <= 300; i++) begin
      rx_push(16'h0500 | 16'(i[7:0]), 1'b0);
      if (i == 253) chk("misroute_254", 32'(misroute_cnt), 32'd254);
      if (i == 254) chk("misroute_255", 32'(misroute_cnt), 32'd255);
    end
    chk("misroute_sat",      32'(misroute_cnt), 32'd255);
    chk("misroute_rx_empty", 32'(rx_empty),     32'd1);

    // Asynchronous reset mid-cycle with data in flight
    tx_write(16'h0777, 1'b0);
    rx_push(16'h0388, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_pndng",    32'(pndng),        32'd0);
    chk("async_dpop",     32'(D_pop),        32'd0);
    chk("async_rx_empty", 32'(rx_empty),     32'd1);
    chk("async_ovf",      32'(rx_overflow),  32'd0);
    chk("async_misroute", 32'(misroute_cnt), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
